// File: rtl/deco_scan_sel_if.sv
// Bundle of control inputs and decoded outputs for deco_scan_sel.
// Ports: en/mode/sel/sel_valid/dwell (controller -> decoder), y/idx/wrap (decoder -> consumer).
// The master modport is the controller side; the slave modport is the decoder.
interface deco_scan_sel_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  sel_valid;
    logic [DWELL_W-1:0]    dwell;
    logic [2**SEL_W-1:0]   y;
    logic [SEL_W-1:0]      idx;
    logic                  wrap;

    modport master (
        output en, mode, sel, sel_valid, dwell,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, sel, sel_valid, dwell,
        output y, idx, wrap
    );
endinterface

// File: rtl/deco_scan_sel.sv
// Registered 1-of-2**SEL_W decoder with an auto-scan sequencer (direct decode or dwell-timed channel walk).
// Latency: one clk from en/mode/sel/sel_valid/dwell to y/idx/wrap; all outputs registered.
// No backpressure: sel is taken whenever sel_valid is high in direct mode; the consumer cannot stall the scan.
// Ports: clk, rst_n (async active-low); bus.slave carries en, mode, sel, sel_valid, dwell in and y, idx, wrap out.
module deco_scan_sel #(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    deco_scan_sel_if.slave   bus
);
    localparam int N = 2**SEL_W;
    // XOR mask that converts an active-high one-hot into the output polarity;
    // it is also the "all inactive" value.
    localparam logic [N-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state, nxt_state;
    logic [SEL_W-1:0]   idx_q, nxt_idx;
    logic [DWELL_W-1:0] cnt_q, nxt_cnt;
    logic [N-1:0]       y_q, nxt_y;
    logic               wrap_q, nxt_wrap;
    logic [N-1:0]       oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= Y_OFF;
            wrap_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            idx_q  <= nxt_idx;
            cnt_q  <= nxt_cnt;
            y_q    <= nxt_y;
            wrap_q <= nxt_wrap;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx_q;
        nxt_cnt   = cnt_q;
        nxt_wrap  = 1'b0;
        oh        = '0;
        nxt_y     = Y_OFF;

        if (!bus.en) begin
            // Blanked: channel index is remembered so a later resume re-displays it.
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
        end else if (!bus.mode) begin
            // Direct decode; a load on a scan->direct switch is honoured and
            // any partial dwell is discarded.
            nxt_state = ST_DIRECT;
            nxt_cnt   = '0;
            if (bus.sel_valid) begin
                nxt_idx = bus.sel;
            end
        end else begin
            nxt_state = ST_SCAN;
            if (state != ST_SCAN) begin
                // Entry edge: show the held channel and start its dwell fresh.
                nxt_cnt = '0;
            end else if (cnt_q >= bus.dwell) begin
                // >= so that shrinking dwell below the running count advances
                // immediately instead of waiting for the counter to wrap.
                nxt_idx  = idx_q + 1'b1;
                nxt_cnt  = '0;
                nxt_wrap = &idx_q;
            end else begin
                nxt_cnt = cnt_q + 1'b1;
            end
        end

        oh[nxt_idx] = 1'b1;
        if (nxt_state != ST_IDLE) begin
            nxt_y = oh ^ Y_OFF;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule
